alu_nibble_seq_ctrl: RTL and testbench

//   Multi-cycle sequencer that performs WIDTH-bit ALU operations on one shared 4-bit

---
 rtl/alu_nibble_seq_ctrl.sv | 146 ++++++++++++++
 tb/tb_alu_nibble_seq_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_nibble_seq_ctrl.sv
// Nibble-serial WIDTH-bit ALU sequencer driving one shared 4-bit ALU slice, LSB nibble first.
// Optional ALU_SEQ_ABORT_EN adds an abort input and a shadow result register committed at completion.
module alu_nibble_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [2:0]       op_in,
`ifdef ALU_SEQ_ABORT_EN
    input  logic             abort,
`endif
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [2:0]       alu_op,
    output logic             alu_cin,
    input  logic [3:0]       alu_result,
    input  logic             alu_cout,
    input  logic             alu_overflow
);
    localparam int NIB = WIDTH / 4;
    localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_result;
    logic [2:0]       r_op;
    logic             r_slt, r_carry, r_carry_out, r_overflow;
    logic [KW-1:0]    r_k;
    logic [2:0]       w_op_map;
    logic             w_run, w_last, w_arith, w_cin, w_lt, w_abort;
    logic [WIDTH-1:0] w_acc, w_final;
`ifdef ALU_SEQ_ABORT_EN
    logic [WIDTH-1:0] r_shadow;
`endif

    assign w_run   = (r_state == RUN);
    assign w_last  = (r_k == KW'(NIB - 1));
    assign w_arith = r_op[1];
    assign w_cin   = (r_k == '0) ? r_op[2] : r_carry;
    assign w_lt    = alu_result[3] ^ alu_overflow;
`ifdef ALU_SEQ_ABORT_EN
    assign w_abort = abort & w_run;
`else
    assign w_abort = 1'b0;
`endif

    // SLT runs as SUB on the ALU; undefined codes collapse to AND.
    always_comb begin
        w_op_map = 3'b000;
        case (op_in)
            3'b001:         w_op_map = 3'b001;
            3'b010:         w_op_map = 3'b010;
            3'b110, 3'b111: w_op_map = 3'b110;
            default:        w_op_map = 3'b000;
        endcase
    end

    always_comb begin
`ifdef ALU_SEQ_ABORT_EN
        w_acc = r_shadow;
`else
        w_acc = r_result;
`endif
        w_acc[{r_k, 2'b00} +: 4] = alu_result;
        w_final = r_slt ? {{(WIDTH-1){1'b0}}, w_lt} : w_acc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = RUN;
            RUN:     if (w_abort) w_next = IDLE;
                     else if (w_last) w_next = FIN;
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_slt       <= 1'b0;
            r_k         <= '0;
            r_carry     <= 1'b0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
`ifdef ALU_SEQ_ABORT_EN
            r_shadow    <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_a   <= a_in;
                    r_b   <= b_in;
                    r_op  <= w_op_map;
                    r_slt <= (op_in == 3'b111);
                    r_k   <= '0;
                end
                RUN: if (!w_abort) begin
                    r_carry <= alu_cout;
                    r_k     <= r_k + 1'b1;
`ifdef ALU_SEQ_ABORT_EN
                    r_shadow <= w_acc;
                    if (w_last) r_result <= w_final;
`else
                    r_result <= w_last ? w_final : w_acc;
`endif
                    if (w_last) begin
                        r_carry_out <= w_arith & alu_cout;
                        r_overflow  <= w_arith & ~r_slt & alu_overflow;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready     = (r_state == IDLE);
    assign done      = (r_state == FIN);
    assign result    = r_result;
    assign carry_out = r_carry_out;
    assign overflow  = r_overflow;
    assign zero      = (r_result == '0);
    assign alu_a     = w_run ? r_a[{r_k, 2'b00} +: 4] : 4'h0;
    assign alu_b     = w_run ? r_b[{r_k, 2'b00} +: 4] : 4'h0;
    assign alu_op    = w_run ? r_op : 3'b000;
    assign alu_cin   = w_run & w_cin;
endmodule

// File: tb/tb_alu_nibble_seq_ctrl.sv
// Scoreboard bench: accepted starts push word-level expected results; a monitor checks on done.
module tb_alu_nibble_seq_ctrl;
    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic         clk = 1'b0, rst_n = 1'b1, start = 1'b0;
    logic         ready, done, carry_out, overflow, zero, alu_cin;
    logic [W-1:0] a_in = '0, b_in = '0, result;
    logic [2:0]   op_in = '0, alu_op;
    logic [3:0]   alu_a, alu_b, alu_result;
    logic         alu_cout, alu_overflow;
    logic [4:0]   alu_s;

    typedef struct {
        logic [W-1:0] a, b, r;
        logic [2:0]   op;
        logic         c, v, z;
        int           acc;
    } exp_t;

    exp_t q[$];
    exp_t last_exp;
    int   acc_log[$];
    int   cyc = 0, ndone = 0, ntests = 0, nfail = 0;

    alu_nibble_seq_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ready(ready),
        .a_in(a_in), .b_in(b_in), .op_in(op_in),
`ifdef ALU_SEQ_ABORT_EN
        .abort(1'b0),
`endif
        .done(done), .result(result), .carry_out(carry_out), .overflow(overflow), .zero(zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
        .alu_result(alu_result), .alu_cout(alu_cout), .alu_overflow(alu_overflow)
    );

    always #5 clk = ~clk;

    // The 4-bit ALU slice the sequencer drives.
    always_comb begin
        alu_s        = '0;
        alu_result   = alu_a & alu_b;
        alu_cout     = 1'b0;
        alu_overflow = 1'b0;
        case (alu_op)
            3'b001: alu_result = alu_a | alu_b;
            3'b010: begin
                alu_s        = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_cin};
                alu_result   = alu_s[3:0];
                alu_cout     = alu_s[4];
                alu_overflow = (alu_a[3] == alu_b[3]) && (alu_s[3] != alu_a[3]);
            end
            3'b110: begin
                alu_s        = {1'b0, alu_a} + {1'b0, ~alu_b} + {4'b0, alu_cin};
                alu_result   = alu_s[3:0];
                alu_cout     = alu_s[4];
                alu_overflow = (alu_a[3] != alu_b[3]) && (alu_s[3] != alu_a[3]);
            end
            default: ;
        endcase
    end

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [2:0] op, input int acc);
        exp_t e;
        logic [W:0] s;
        e.a = a; e.b = b; e.op = op; e.acc = acc;
        e.r = a & b; e.c = 1'b0; e.v = 1'b0;
        s = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
        case (op)
            3'd1: e.r = a | b;
            3'd2: begin
                s   = {1'b0, a} + {1'b0, b};
                e.r = s[W-1:0]; e.c = s[W];
                e.v = (a[W-1] == b[W-1]) && (e.r[W-1] != a[W-1]);
            end
            3'd6: begin
                e.r = s[W-1:0]; e.c = s[W];
                e.v = (a[W-1] != b[W-1]) && (e.r[W-1] != a[W-1]);
            end
            3'd7: begin
                e.c = s[W];
                e.r = ($signed(a) < $signed(b)) ? W'(1) : '0;
            end
            default: ;
        endcase
        e.z = (e.r == '0);
        return e;
    endfunction

    function automatic logic [2:0] map_op(input logic [2:0] op);
        case (op)
            3'd1:       return 3'b001;
            3'd2:       return 3'b010;
            3'd6, 3'd7: return 3'b110;
            default:    return 3'b000;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Acceptance tracker: cyc holds the index of the edge being sampled.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && start && ready) begin
            q.push_back(model(a_in, b_in, op_in, cyc));
            acc_log.push_back(cyc);
        end
    end

    // Monitor: per-nibble ALU drive while busy, full result check on done.
    always @(negedge clk) begin
        if (rst_n) begin
            if (q.size() > 0 && !done) begin
                automatic int k = cyc - q[0].acc - 1;
                if (k >= 0 && k < NIB) begin
                    chk("alu_a", 32'(alu_a), 32'(q[0].a[k*4 +: 4]));
                    chk("alu_b", 32'(alu_b), 32'(q[0].b[k*4 +: 4]));
                    chk("alu_op", 32'(alu_op), 32'(map_op(q[0].op)));
                    if (k == 0)
                        chk("alu_cin_nib0", 32'(alu_cin), 32'(q[0].op == 3'd6 || q[0].op == 3'd7));
                end
            end
            if (done) begin
                ndone++;
                if (q.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'(0));
                end else begin
                    automatic exp_t e = q.pop_front();
                    chk("result", 32'(result), 32'(e.r));
                    chk("carry_out", 32'(carry_out), 32'(e.c));
                    chk("overflow", 32'(overflow), 32'(e.v));
                    chk("zero", 32'(zero), 32'(e.z));
                    chk("done_latency", 32'(cyc - e.acc), 32'(NIB + 1));
                    last_exp = e;
                end
            end
        end
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
        int n = 0;
        while (!ready && n < 50) begin @(negedge clk); n++; end
        chk("ready_timeout", 32'(n < 50), 32'(1));
        start = 1'b1; a_in = a; b_in = b; op_in = op;
        @(negedge clk);
        start = 1'b0;
        a_in = W'($urandom); b_in = W'($urandom); op_in = 3'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || !ready) && n < 200) begin @(negedge clk); n++; end
        chk("drain_timeout", 32'(n < 200), 32'(1));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, 32'(ready), 32'(1));
        chk({tag, "_done"}, 32'(done), 32'(0));
        chk({tag, "_result"}, 32'(result), 32'(0));
        chk({tag, "_carry"}, 32'(carry_out), 32'(0));
        chk({tag, "_ovf"}, 32'(overflow), 32'(0));
        chk({tag, "_zero"}, 32'(zero), 32'(1));
        chk({tag, "_alu_ab"}, 32'({alu_a, alu_b}), 32'(0));
        chk({tag, "_alu_op_cin"}, 32'({alu_op, alu_cin}), 32'(0));
    endtask

    initial begin
        int n0, d0;
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("rst");
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        run_op(16'h00FF, 16'h0001, 3'd2);
        run_op(16'h1234, 16'h1234, 3'd6);
        run_op(16'h7FFF, 16'h0001, 3'd2);
        run_op(16'hFFFF, 16'h0001, 3'd2);
        run_op(16'hFFFF, 16'h0001, 3'd7);
        run_op(16'h8000, 16'h7FFF, 3'd7);
        run_op(16'h0003, 16'h0002, 3'd7);
        run_op(16'hF0F0, 16'h3C3C, 3'd0);
        drain();

        // Outputs hold while idle.
        repeat (3) @(negedge clk);
        chk("hold_result", 32'(result), 32'(last_exp.r));
        chk("hold_zero", 32'(zero), 32'(last_exp.z));

        // start held for 10 cycles: two accepts, NIB+2 apart.
        n0 = acc_log.size();
        start = 1'b1; a_in = W'($urandom); b_in = W'($urandom); op_in = 3'd2;
        repeat (10) @(negedge clk);
        start = 1'b0;
        drain();
        chk("held_start_ops", 32'(acc_log.size() - n0), 32'(2));
        if (acc_log.size() - n0 >= 2)
            chk("held_start_spacing", 32'(acc_log[n0+1] - acc_log[n0]), 32'(NIB + 2));

        // Reset during nibble 2 of an op: no done, reset values, then normal operation.
        run_op(16'hA5C3, 16'h0F0F, 3'd1);
        @(negedge clk); @(negedge clk);
        d0 = ndone;
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("midrst");
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("midrst_no_done", 32'(ndone - d0), 32'(0));
        run_op(16'h1111, 16'h2222, 3'd2);
        drain();
        chk("post_rst_done", 32'(ndone - d0), 32'(1));

        // Randomised back-to-back traffic, all op codes.
        for (int i = 0; i < 40; i++)
            run_op(W'($urandom), W'($urandom), 3'($urandom_range(0, 7)));
        drain();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
